expr_sig_collector: RTL and testbench

- Downstream stage of the generated expression blocks in the regression harness.
- Consumes the 90-bit packed result bus y, one vector per accepted handshake, and compresses the stream into a 32-bit MISR signature.
- After a programmed number of vectors, compares the signature against a golden value and reports pass/fail.
- Allows whole-run equivalence checking of original vs. synthesized expression netlists without storing every result.

---
 rtl/expr_sig_collector_if.sv | 18 +
 rtl/expr_sig_collector.sv | 151 +++++++++++++++
 tb/tb_expr_sig_collector.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/expr_sig_collector_if.sv
// rtl/expr_sig_collector_if.sv - result-vector handshake bus into the signature collector
//
// Ports (signals):
//   y_valid  upstream result valid
//   y_ready  collector accepts y this cycle
//   y        packed expression result, Y_W bits (y0 in MSBs)
// Modports: master drives y_valid/y, slave drives y_ready.

interface expr_sig_collector_if #(
    parameter int Y_W = 90
);
    logic           y_valid;
    logic           y_ready;
    logic [Y_W-1:0] y;

    modport master (output y_valid, output y, input y_ready);
    modport slave  (input y_valid, input y, output y_ready);
endinterface

// File: rtl/expr_sig_collector.sv
// rtl/expr_sig_collector.sv - MISR signature collector with golden compare for expression results
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a run (sampled only in IDLE or DONE)
//   num_vec, golden      run length and expected signature, latched with start
//   yb                   slave side of the y_valid/y_ready/y handshake
//   busy                 high in RUN and CHECK
//   done                 one-cycle pulse when a run finishes
//   pass                 signature == golden, valid from done until next start
//   signature            current MISR value
//   vec_count            vectors absorbed in the current run
//   field_toggled        (only with EXPR_SIG_FIELD_COV_EN) sticky per-field change flags
//
// Optional feature macro: EXPR_SIG_FIELD_COV_EN

module expr_sig_collector #(
    parameter int          Y_W   = 90,
    parameter int          CNT_W = 16,
    parameter logic [31:0] SEED  = 32'hFFFF_FFFF,
    parameter logic [31:0] POLY  = 32'h0040_0007
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic [31:0]       golden,
    expr_sig_collector_if.slave yb,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       signature,
    output logic [CNT_W-1:0]  vec_count
`ifdef EXPR_SIG_FIELD_COV_EN
    ,
    output logic [17:0]       field_toggled
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Fold works on three 32-bit words; bits above Y_W read as zero.
    localparam int PAD_W = 96;

    logic [1:0]       state;
    logic [31:0]      golden_q;
    logic [CNT_W-1:0] num_q;
    logic [PAD_W-1:0] y_pad;
    logic [31:0]      fold_y;
    logic [31:0]      sig_next;
    logic [CNT_W-1:0] cnt_next;
    logic             xfer;

    assign yb.y_ready = (state == S_RUN);
    assign busy       = (state == S_RUN) || (state == S_CHECK);
    assign xfer       = yb.y_valid && (state == S_RUN);

    assign y_pad    = {{(PAD_W-Y_W){1'b0}}, yb.y};
    assign fold_y   = y_pad[31:0] ^ y_pad[63:32] ^ y_pad[95:64];
    assign sig_next = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold_y;
    assign cnt_next = vec_count + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            signature <= SEED;
            vec_count <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            golden_q  <= '0;
            num_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        signature <= SEED;
                        vec_count <= '0;
                        num_q     <= num_vec;
                        golden_q  <= golden;
                        pass      <= 1'b0;
                        state     <= (num_vec == '0) ? S_CHECK : S_RUN;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        signature <= sig_next;
                        vec_count <= cnt_next;
                        // vec_count stops exactly at num_q, so it cannot wrap.
                        if (cnt_next == num_q) begin
                            state <= S_CHECK;
                        end
                    end
                end
                default: begin
                    pass  <= (signature == golden_q);
                    done  <= 1'b1;
                    state <= S_DONE;
                end
            endcase
        end
    end

`ifdef EXPR_SIG_FIELD_COV_EN
    // Field k occupies a slice counted down from the MSB; widths repeat 4,5,6.
    function automatic logic [Y_W-1:0] field_mask(input int k);
        int               w;
        int               off;
        logic [Y_W-1:0]   m;
        w   = (k % 3 == 0) ? 4 : ((k % 3 == 1) ? 5 : 6);
        off = (k / 3) * 15 + ((k % 3 == 0) ? 0 : ((k % 3 == 1) ? 4 : 9));
        m   = '0;
        m[0] = 1'b1;
        m   = ((m << w) - 1'b1) << (Y_W - off - w);
        return m;
    endfunction

    logic [Y_W-1:0] prev_y;
    logic           have_prev;
    logic [17:0]    field_diff;

    always_comb begin
        field_diff = '0;
        for (int k = 0; k < 18; k++) begin
            field_diff[k] = |((yb.y ^ prev_y) & field_mask(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_y        <= '0;
            have_prev     <= 1'b0;
            field_toggled <= '0;
        end else if ((state == S_IDLE || state == S_DONE) && start) begin
            have_prev     <= 1'b0;
            field_toggled <= '0;
        end else if (xfer) begin
            prev_y    <= yb.y;
            have_prev <= 1'b1;
            // The first vector of a run has nothing to compare against.
            if (have_prev) begin
                field_toggled <= field_toggled | field_diff;
            end
        end
    end
`endif

endmodule

// File: tb/tb_expr_sig_collector.sv
// tb/tb_expr_sig_collector.sv - scoreboard bench for expr_sig_collector

module tb_expr_sig_collector;

    localparam logic [31:0] SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY = 32'h0040_0007;

    typedef struct packed {
        logic [31:0] sig;
        logic        pass;
        logic [15:0] cnt;
        logic [17:0] tog;
    } done_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vec;
    logic [31:0] golden;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;
    logic [15:0] vec_count;
`ifdef EXPR_SIG_FIELD_COV_EN
    logic [17:0] field_toggled;
`endif

    expr_sig_collector_if #(.Y_W(90)) yb ();

    expr_sig_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_vec   (num_vec),
        .golden    (golden),
        .yb        (yb),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .vec_count (vec_count)
`ifdef EXPR_SIG_FIELD_COV_EN
        ,
        .field_toggled (field_toggled)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_sig_q[$];
    done_t       done_q[$];
    logic [89:0] vecs[$];

    // Reference model state
    logic [31:0] msig;
    logic [15:0] mcnt;
    logic [15:0] mnum;
    logic [31:0] mgold;
    logic [17:0] mtog;
    logic [89:0] mprev;
    bit          mhave;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [89:0] y);
        logic [31:0] f;
        f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
        return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    function automatic int fw(input int k);
        return (k % 3 == 0) ? 4 : ((k % 3 == 1) ? 5 : 6);
    endfunction

    function automatic logic [17:0] fields_changed(input logic [89:0] a, input logic [89:0] b);
        logic [17:0] r;
        logic [89:0] mask;
        int pos;
        r   = '0;
        pos = 90;
        for (int k = 0; k < 18; k++) begin
            pos  = pos - fw(k);
            mask = (90'd1 << fw(k)) - 90'd1;
            r[k] = ((((a ^ b) >> pos) & mask) != 90'd0);
        end
        return r;
    endfunction

    function automatic logic [89:0] gen_y(input logic [89:0] prev);
        logic [95:0] r;
        logic [89:0] one;
        one = 90'd1;
        case ($urandom_range(0, 3))
            0: begin r = {$urandom, $urandom, $urandom}; return r[89:0]; end
            1: return prev;
            2: return prev ^ (one << $urandom_range(0, 89));
            default: return '0;
        endcase
    endfunction

    // Monitor: checks signature one cycle after every transfer, and results at every done.
    bit          pend = 0;
    logic [31:0] pend_sig;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend) begin
                chk("sig_after_xfer", signature, pend_sig);
                pend = 0;
            end
            if (yb.y_valid && yb.y_ready) begin
                if (exp_sig_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL xfer_unexpected: got transfer expected none");
                end else begin
                    pend_sig = exp_sig_q.pop_front();
                    pend     = 1;
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done=1 expected 0");
                end else begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("done_sig",  signature, e.sig);
                    chk("done_pass", pass, e.pass);
                    chk("done_cnt",  vec_count, e.cnt);
`ifdef EXPR_SIG_FIELD_COV_EN
                    chk("done_tog",  field_toggled, e.tog);
`endif
                end
            end
        end
    end

    task automatic do_start(input logic [15:0] nv, input logic [31:0] g);
        @(posedge clk); #1;
        start = 1'b1; num_vec = nv; golden = g;
        msig = SEED; mcnt = 0; mnum = nv; mgold = g; mtog = '0; mhave = 0;
        if (nv == 0) done_q.push_back('{sig: SEED, pass: (SEED == g), cnt: 16'd0, tog: 18'd0});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [89:0] y, input int stall);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_hold", signature, msig);
            @(posedge clk); #1;
        end
        yb.y_valid = 1'b1; yb.y = y;
        msig = misr_step(msig, y);
        mcnt++;
        if (mhave) mtog = mtog | fields_changed(y, mprev);
        mprev = y; mhave = 1;
        exp_sig_q.push_back(msig);
        if (mcnt == mnum) done_q.push_back('{sig: msig, pass: (msig == mgold), cnt: mcnt, tog: mtog});
        @(posedge clk); #1;
        yb.y_valid = 1'b0;
    endtask

    task automatic wait_finish();
        @(negedge clk);
        chk("check_done_low", done, 1'b0);
        chk("check_busy",     busy, 1'b1);
        chk("check_ready",    yb.y_ready, 1'b0);
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("done_busy",  busy, 1'b0);
        @(negedge clk);
        chk("done_cleared", done, 1'b0);
    endtask

    task automatic idle_garbage();
        logic [95:0] r;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            r = {$urandom, $urandom, $urandom};
            yb.y_valid = 1'b1; yb.y = r[89:0];
            @(negedge clk);
            chk("idle_ready", yb.y_ready, 1'b0);
        end
        @(posedge clk); #1;
        yb.y_valid = 1'b0;
        chk("idle_sig",  signature, msig);
        chk("idle_cnt",  vec_count, mcnt);
        chk("idle_pass", pass, (msig == mgold));
    endtask

    task automatic run_vecs(input bit force_gold, input logic [31:0] gval, input int max_stall);
        logic [31:0] e;
        logic [31:0] g;
        e = SEED;
        foreach (vecs[i]) e = misr_step(e, vecs[i]);
        g = force_gold ? gval : e;
        do_start(16'(vecs.size()), g);
        foreach (vecs[i]) send(vecs[i], (i == 0) ? 0 : max_stall);
        wait_finish();
        idle_garbage();
    endtask

    initial begin
        logic [89:0] t;
        logic [31:0] gv;
        rst_n = 1'b0; start = 1'b0; num_vec = '0; golden = '0;
        yb.y_valid = 1'b0; yb.y = '0;
        msig = SEED; mcnt = 0; mnum = 0; mgold = 0; mtog = 0; mprev = 0; mhave = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_sig",  signature, SEED);
        chk("rst_cnt",  vec_count, 16'd0);
        chk("rst_ready", yb.y_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_garbage();

        // single vector, matching golden
        vecs = {90'd1};
        run_vecs(0, 0, 0);
        // two vectors with a 3-cycle stall, wrong golden
        vecs = {90'd1, 90'd1};
        run_vecs(1, 32'h0, 3);
        // fold cancellation across the words
        t = (90'd1 << 64);
        vecs = {t, (90'd1 << 32) | 90'd1};
        run_vecs(0, 0, 0);
        // zero-length run: straight to CHECK, seed equals golden
        vecs.delete();
        run_vecs(1, 32'hFFFF_FFFF, 0);
        // single MSB field change
        vecs = {90'd0, (90'd1 << 89)};
        run_vecs(0, 0, 1);

        // start ignored while busy, then reset mid-run
        vecs.delete();
        for (int i = 0; i < 4; i++) vecs.push_back(gen_y(90'd5));
        do_start(16'd4, $urandom);
        send(vecs[0], 0);
        send(vecs[1], 0);
        @(posedge clk); #1;
        start = 1'b1; num_vec = 16'd7; golden = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        send(vecs[2], 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_pass", pass, 1'b0);
        chk("midrst_sig",  signature, SEED);
        chk("midrst_cnt",  vec_count, 16'd0);
        chk("midrst_ready", yb.y_ready, 1'b0);
`ifdef EXPR_SIG_FIELD_COV_EN
        chk("midrst_tog", field_toggled, 18'd0);
`endif
        exp_sig_q.delete();
        done_q.delete();
        msig = SEED; mcnt = 0; mgold = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", done, 1'b0);
        run_vecs(0, 0, 1);

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            t = '0;
            vecs.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++) begin
                t = gen_y(t);
                vecs.push_back(t);
            end
            gv = $urandom;
            run_vecs($urandom_range(0, 1), gv, $urandom_range(0, 2));
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_sig_empty",  exp_sig_q.size(), 0);
        chk("scoreboard_done_empty", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
